// File: rtl/matrix_row_tx.sv
// -----------------------------------------------------------------------------
// matrix_row_tx
//
// Sends a captured 6x6 binary matrix out on an 8-bit bus, one row per beat,
// followed by a summary beat carrying the population count of the matrix.
// Every beat is qualified by a strobe and completes on a valid/ready handshake.
// The matrix is copied into a shadow register on start, so the source may
// change freely while a frame is in flight.
//
// Parameters:
//   GAP_CYCLES   idle (strobe-low) cycles inserted between row beats (0..15)
//   STALL_LIMIT  consecutive stalled cycles before a beat is abandoned
//                (0 = wait forever, 1..255)
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n_n    in   1  synchronous reset, active high
//   start      in   1  capture matrix_in and send a frame (accepted when idle)
//   matrix_in  in  36  row-major matrix, row i bit j = matrix_in[6*i+j]
//   tx_ready   in   1  downstream accepts the beat at an edge with strobe high
//   uo_out     out  8  [5:0] payload, [6] strobe, [7] summary-beat flag
//   busy       out  1  a frame is in progress
//   done       out  1  one-cycle pulse after the summary beat is accepted
//   err        out  1  one-cycle pulse after a stall abort
// -----------------------------------------------------------------------------
module matrix_row_tx #(
  parameter int unsigned GAP_CYCLES  = 0,
  parameter int unsigned STALL_LIMIT = 0
) (
  input  logic        clk,
  input  logic        rst_n_n,
  input  logic        start,
  input  logic [35:0] matrix_in,
  input  logic        tx_ready,
  output logic [7:0]  uo_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_SUM
  } state_t;

  // Last value of each down/up counter; only meaningful when the feature is on.
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);
  localparam logic [7:0] STALL_LAST = 8'(STALL_LIMIT - 1);
  localparam bit         GAP_EN     = (GAP_CYCLES != 0);
  localparam bit         STALL_EN   = (STALL_LIMIT != 0);

  state_t      r_state, w_state_nxt;
  logic [35:0] r_shadow;
  logic [5:0]  r_pop;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [3:0]  r_gap, w_gap_nxt;
  logic [7:0]  r_stall, w_stall_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;
  logic        w_load;
  logic        w_strobe;
  logic [5:0]  w_row;
  logic [5:0]  w_pop;

  function automatic logic [5:0] popcount36(input logic [35:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int k = 0; k < 36; k++) begin
      cnt = cnt + {5'b0, v[k]};
    end
    return cnt;
  endfunction

  assign w_pop    = popcount36(matrix_in);
  assign w_strobe = (r_state == S_SEND) || (r_state == S_SUM);
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign err      = r_err;

  // Row selector for the current beat.
  always_comb begin
    w_row = '0;
    case (r_idx)
      3'd0:    w_row = r_shadow[5:0];
      3'd1:    w_row = r_shadow[11:6];
      3'd2:    w_row = r_shadow[17:12];
      3'd3:    w_row = r_shadow[23:18];
      3'd4:    w_row = r_shadow[29:24];
      3'd5:    w_row = r_shadow[35:30];
      default: w_row = '0;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_gap_nxt   = r_gap;
    w_stall_nxt = r_stall;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;
    uo_out      = 8'h00;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_idx_nxt   = '0;
          w_stall_nxt = '0;
          w_state_nxt = S_SEND;
        end
      end

      S_SEND: begin
        uo_out = {2'b01, w_row};
        if (tx_ready) begin
          if (r_idx == 3'd5) begin
            w_state_nxt = S_SUM;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
            if (GAP_EN) begin
              w_gap_nxt   = GAP_LAST;
              w_state_nxt = S_GAP;
            end
          end
        end
      end

      // r_gap counts down to zero, giving exactly GAP_CYCLES idle cycles.
      S_GAP: begin
        if (r_gap == 4'd0) begin
          w_state_nxt = S_SEND;
        end else begin
          w_gap_nxt = r_gap - 4'd1;
        end
      end

      S_SUM: begin
        uo_out = {2'b11, r_pop};
        if (tx_ready) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // Stall supervision applies to any strobe-high beat. The abort fires on
    // the edge at which the count would reach STALL_LIMIT.
    if (w_strobe) begin
      if (tx_ready) begin
        w_stall_nxt = '0;
      end else if (STALL_EN) begin
        if (r_stall == STALL_LAST) begin
          w_stall_nxt = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_stall_nxt = r_stall + 8'd1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst_n_n) begin
      r_state <= S_IDLE;
      // NOTE: the shadow register is cleared on reset so no stale matrix
      // survives an abandoned frame; it is a plain register, not a RAM.
      r_shadow <= '0;
      r_pop    <= '0;
      r_idx    <= '0;
      r_gap    <= '0;
      r_stall  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_gap   <= w_gap_nxt;
      r_stall <= w_stall_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (w_load) begin
        r_shadow <= matrix_in;
        r_pop    <= w_pop;
      end
    end
  end

endmodule

// File: doc/matrix_row_tx.md
Name: matrix_row_tx

Overview:
Transmit-side counterpart of the 6x6 button-matrix row loader. The loader receives rows as ui_in[5:0] with a row strobe on ui_in[6]. This block sends a captured 36-bit binary matrix back out on the 8-bit uo_out bus in the same framing: six row beats, then one summary beat carrying the population count. Each beat uses a valid/ready handshake. It sits between the convolution datapath (matrix_in) and the chip output pins or a downstream row loader.

Parameters:
GAP_CYCLES, 0, idle cycles with strobe low inserted between consecutive row beats (0..15).
STALL_LIMIT, 0, maximum consecutive cycles a beat may wait for tx_ready before abort (0 = never abort; 1..255).

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n_n  input  1  reset; synchronous, active-high (the name is historical; polarity is active-high)
start  input  1  request to capture matrix_in and transmit; honoured only in IDLE
matrix_in  input  36  row-major matrix; row i bit j = matrix_in[6*i+j]
tx_ready  input  1  downstream accepts the current beat at a rising edge where the strobe is also high
uo_out  output  8  [5:0] payload, [6] beat strobe (valid), [7] summary-beat flag
busy  output  1  high from the cycle after start is accepted until the cycle done pulses
done  output  1  one-cycle pulse after the summary beat is accepted
err  output  1  one-cycle pulse on stall abort

Behaviour:
- Reset (rst_n_n=1 at an edge): next cycle uo_out=8'h00, busy=0, done=0, err=0, state IDLE, row index 0, stall counter 0, shadow register cleared. This applies mid-transfer too; the frame is abandoned with no done and no err.
- States: IDLE, SEND, GAP, SUM.
- IDLE: uo_out=0, busy=0. If start=1 at an edge:
  - matrix_in is copied to a 36-bit shadow register.
  - popcount(matrix_in) (0..36) is registered.
  - Row index is set to 0 and the state goes to SEND.
  - Latency: the first row beat is visible the cycle after start is sampled.
- SEND: uo_out = {1'b0, 1'b1, shadow row[idx]}. On an edge with tx_ready=1:
  - If idx==5, go to SUM.
  - Otherwise idx++, and go to GAP if GAP_CYCLES>0, else stay in SEND with the next row (back-to-back beats).
- GAP: uo_out = {2'b00, 6'b0} for exactly GAP_CYCLES cycles, then SEND. tx_ready is ignored in GAP.
- SUM: uo_out = {1'b1, 1'b1, popcount[5:0]}. On tx_ready=1:
  - State goes to IDLE.
  - done=1 for exactly the next cycle; busy=0 in that same cycle.
- Beat hold: while the strobe is high and tx_ready=0, uo_out stays bit-stable.
- The shadow register isolates transmission; matrix_in changes while busy have no effect.
- start while busy is ignored and not queued. start on the same edge as the summary handshake is ignored (state is not yet IDLE). start in the done cycle is accepted.
- Throughput: with GAP_CYCLES=0 and tx_ready held high, a frame is 7 consecutive strobe-high cycles. Minimum start-to-start spacing is 8 cycles.
- Stall, STALL_LIMIT>0:
  - The counter increments each cycle the strobe is high with tx_ready=0.
  - It clears on each handshake.
  - When it reaches STALL_LIMIT, the next cycle has state IDLE, uo_out=0, err=1 for one cycle, busy=0, and no done.
- Stall, STALL_LIMIT=0: the block waits indefinitely.
- Payload bit 0 = column 0. Popcount arithmetic is 6-bit unsigned; the maximum 36 fits without saturation.

Test Plan:
1. Reset, then start with matrix_in=36'hF_FFFF_FFFF, tx_ready=1, GAP_CYCLES=0 -> uo_out=8'h7F for 6 cycles, then 8'hE4, done pulses the following cycle, busy high for 7 cycles.
2. matrix_in=36'hA_AAAA_AAAA, tx_ready=1 -> six beats of 8'h6A, summary 8'hD2 (popcount 18).
3. matrix_in=36'h0_0000_0001, tx_ready toggled 0/1 each cycle, GAP_CYCLES=2 -> row0=8'h41, rows1-5=8'h40, each beat held stable until accepted, 2 strobe-low cycles between rows, summary 8'hC1.
4. start re-asserted mid-frame with a different matrix_in -> frame content unchanged, no second frame; start in the done cycle -> new frame begins the next cycle.
5. STALL_LIMIT=4, tx_ready=0 after the row1 handshake -> after 4 stalled cycles uo_out=0, err pulses once, no done.
6. rst_n_n=1 during the row3 beat -> the next cycle uo_out=0, busy=0, done=0; a subsequent start sends a full frame correctly.
